// File: rtl/ws2812_driver.sv
// WS2812 serial LED driver: accepts one 24-bit colour per frame, resends it to NUM_LEDS LEDs, then holds the line low to latch.
// Optional build macro WS2812_DIM_EN: quarter brightness (each channel >> 2 at capture).
module ws2812_driver #(
    parameter int NUM_LEDS = 1,
    parameter int T0H_CYC  = 4,
    parameter int T1H_CYC  = 8,
    parameter int TBIT_CYC = 15,
    parameter int TRST_CYC = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb_in,
    input  logic        rgb_valid,
    output logic        rgb_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a word transfers on a rising edge where rgb_valid and rgb_ready are both 1.
    // rgb_ready is high only in IDLE; nothing on rgb_in is looked at in any other state.

    localparam int PH_W  = $clog2(TBIT_CYC);
    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LAT_W = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TBIT_CYC - 1);
    localparam logic [PH_W-1:0]  T0H_P    = PH_W'(T0H_CYC);
    localparam logic [PH_W-1:0]  T1H_P    = PH_W'(T1H_CYC);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRST_CYC - 1);
    localparam logic [4:0]       BIT_LAST = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BIT   = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t             r_state;
    logic [23:0]        r_hold;
    logic [4:0]         r_bit_cnt;
    logic [LED_W-1:0]   r_led_cnt;
    logic [PH_W-1:0]    r_phase;
    logic [LAT_W-1:0]   r_latch_cnt;
    logic               r_frame_latch;
    logic               r_dout;
    logic               r_frame_done;

    state_t             w_state;
    logic [23:0]        w_hold;
    logic [4:0]         w_bit_cnt;
    logic [LED_W-1:0]   w_led_cnt;
    logic [PH_W-1:0]    w_phase;
    logic [LAT_W-1:0]   w_latch_cnt;
    logic               w_frame_latch;
    logic               w_frame_done;
    logic               w_tx_bit;
    logic               w_dout;

    function automatic logic [23:0] capture(input logic [23:0] w);
`ifdef WS2812_DIM_EN
        return {2'b00, w[23:18], 2'b00, w[15:10], 2'b00, w[7:2]};
`else
        return w;
`endif
    endfunction

    // Wire order is green, red, blue, each MSB first.
    function automatic logic tx_bit(input logic [23:0] h, input logic [4:0] idx);
        logic [23:0] seq;
        seq = {h[15:8], h[23:16], h[7:0]};
        return seq[BIT_LAST - idx];
    endfunction

    always_comb begin
        w_state       = r_state;
        w_hold        = r_hold;
        w_bit_cnt     = r_bit_cnt;
        w_led_cnt     = r_led_cnt;
        w_phase       = r_phase;
        w_latch_cnt   = r_latch_cnt;
        w_frame_latch = r_frame_latch;
        w_frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rgb_valid) begin
                    w_state   = S_BIT;
                    w_hold    = capture(rgb_in);
                    w_bit_cnt = '0;
                    w_led_cnt = '0;
                    w_phase   = '0;
                end
            end
            S_BIT: begin
                if (r_phase == PH_LAST) begin
                    w_phase = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt = '0;
                        if (r_led_cnt == LED_LAST) begin
                            w_led_cnt     = '0;
                            w_state       = S_LATCH;
                            w_latch_cnt   = '0;
                            w_frame_latch = 1'b1;
                        end else begin
                            w_led_cnt = r_led_cnt + 1'b1;
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt + 5'd1;
                    end
                end else begin
                    w_phase = r_phase + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_latch_cnt == LAT_LAST) begin
                    w_state       = S_IDLE;
                    w_latch_cnt   = '0;
                    // Only a latch that closes a transmitted frame reports completion.
                    w_frame_done  = r_frame_latch;
                    w_frame_latch = 1'b0;
                end else begin
                    w_latch_cnt = r_latch_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_LATCH;
            end
        endcase
        // dout is registered from the next-cycle bit position, so the line rises the cycle after acceptance.
        w_tx_bit = tx_bit(w_hold, w_bit_cnt);
        w_dout   = (w_state == S_BIT) && (w_phase < (w_tx_bit ? T1H_P : T0H_P));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_LATCH;
            r_hold        <= '0;
            r_bit_cnt     <= '0;
            r_led_cnt     <= '0;
            r_phase       <= '0;
            r_latch_cnt   <= '0;
            r_frame_latch <= 1'b0;
            r_dout        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hold        <= w_hold;
            r_bit_cnt     <= w_bit_cnt;
            r_led_cnt     <= w_led_cnt;
            r_phase       <= w_phase;
            r_latch_cnt   <= w_latch_cnt;
            r_frame_latch <= w_frame_latch;
            r_dout        <= w_dout;
            r_frame_done  <= w_frame_done;
        end
    end

    assign rgb_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign dout        = r_dout;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver (3 chained LEDs): random colour requests, a cycle-level busy/ready model and a bit scoreboard decoded from dout pulses.
module tb_ws2812_driver;
  localparam int N_LEDS = 3;
  localparam int T0H = 4;
  localparam int T1H = 8;
  localparam int TBIT = 15;
  localparam int TRST = 600;
  localparam int FRAME_CYC = N_LEDS * 24 * TBIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] rgb_in = '0;
  logic rgb_valid = 1'b0;
  logic rgb_ready, dout, busy, frame_done;
  logic [1:0] dbg_state;

  ws2812_driver #(
    .NUM_LEDS(N_LEDS), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .dout(dout), .busy(busy), .frame_done(frame_done), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [0:0] exp_q[$];
  int exp_rise_q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_on = 1'b0;
  int m_left = 0;
  bit m_frame = 1'b0;
  bit m_fd = 1'b0;
  bit rst_d = 1'b0;
  int acc_cnt = 0;
  int hi_len = 0;
  int last_rise = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Expected bit stream of one frame, straight from the colour word.
  task automatic push_frame(input logic [23:0] w);
    logic [7:0] r, g, b;
    logic [23:0] seq;
    r = w[23:16];
    g = w[15:8];
    b = w[7:0];
`ifdef WS2812_DIM_EN
    r = r >> 2;
    g = g >> 2;
    b = b >> 2;
`endif
    seq = {g, r, b};
    for (int led = 0; led < N_LEDS; led++)
      for (int i = 23; i >= 0; i--)
        exp_q.push_back(seq[i]);
  endtask

  // monitor: compare this cycle, then advance the model to the next cycle
  always @(negedge clk) begin
    if (m_on) begin
      check("rgb_ready", {31'd0, rgb_ready}, {31'd0, m_left == 0});
      check("busy", {31'd0, busy}, {31'd0, m_left != 0});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      if (frame_done) check("bits_outstanding_at_done", exp_q.size(), 0);
    end
    if (rst_d) begin
      check("dout_after_rst", {31'd0, dout}, 32'd0);
      hi_len = 0;
      last_rise = -1;
    end else if (m_on) begin
      if (dout) begin
        if (hi_len == 0) begin
          if (last_rise < 0) begin
            if (exp_rise_q.size() == 0) flag("unexpected_rise");
            else check("first_rise_cycle", cyc, exp_rise_q.pop_front());
          end else begin
            check("bit_period", cyc - last_rise, TBIT);
          end
          last_rise = cyc;
        end
        hi_len++;
      end else if (hi_len > 0) begin
        if (exp_q.size() == 0) flag("unexpected_pulse");
        else check("bit_high_width", hi_len, (exp_q.pop_front() == 1'b1) ? T1H : T0H);
        if (exp_q.size() == 0) last_rise = -1;
        hi_len = 0;
      end
    end
    rst_d = rst;
    if (rst) begin
      m_on = 1'b1;
      m_left = TRST;
      m_frame = 1'b0;
      m_fd = 1'b0;
      exp_q.delete();
      exp_rise_q.delete();
    end else if (m_on) begin
      m_fd = 1'b0;
      if (m_left > 0) begin
        if (m_left == 1 && m_frame) begin
          m_fd = 1'b1;
          m_frame = 1'b0;
        end
        m_left--;
      end else if (rgb_valid) begin
        m_left = FRAME_CYC + TRST;
        m_frame = 1'b1;
        push_frame(rgb_in);
        exp_rise_q.push_back(cyc + 1);
        acc_cnt++;
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic wait_accept(input int start);
    for (int i = 0; i < 4000 && acc_cnt == start; i++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt == start) flag("accept_timeout");
  endtask

  task automatic send(input logic [23:0] w);
    int start;
    start = acc_cnt;
    rgb_in = w;
    rgb_valid = 1'b1;
    wait_accept(start);
    rgb_valid = 1'b0;
    rgb_in = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && m_left != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (m_left != 0) flag("idle_timeout");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int start;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    wait_idle();

    // single frame: one colour channel set
    send(24'hFF0000);
    wait_idle();

    // valid held: rgb_in changes mid-frame, next word taken on the completion cycle
    start = acc_cnt;
    rgb_in = 24'h00FF00;
    rgb_valid = 1'b1;
    wait_accept(start);
    rgb_in = 24'hFFFFFF;
    idle_cycles(300);
    rgb_in = 24'h0000FF;
    wait_accept(start + 1);
    rgb_valid = 1'b0;
    wait_idle();

    // reset during bit 10 of a frame
    send(24'hA5C3F0);
    idle_cycles(10 * TBIT + 2);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    wait_idle();

    // boundary words
    send(24'h000000);
    send(24'hFFFFFF);
    send(24'h0000FF);
    wait_idle();

    // random words with random idle gaps
    for (int k = 0; k < 8; k++) begin
      idle_cycles($urandom_range(0, 20));
      send($urandom);
    end
    wait_idle();
    idle_cycles(5);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
